// File: rtl/lsu_mem_controller_if.sv
// Data-memory port between the load/store sequencer (master) and a
// req/gnt/rvalid data memory (slave).
interface lsu_mem_controller_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_controller.sv
// Multi-cycle load/store sequencer: stalls the core while a word-aligned
// access runs on the data-memory port, then retires it with formatted load data.
module lsu_mem_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_req_valid,
  input  logic [2:0]           lsu_func,
  input  logic [31:0]          lsu_addr,
  input  logic [31:0]          lsu_wdata,
  output logic                 lsu_stall,
  output logic                 lsu_done,
  output logic [31:0]          lsu_rdata,
  output logic                 lsu_misaligned,
  output logic                 lsu_bus_err,
  lsu_mem_controller_if.master mem
);

  localparam logic [2:0] F_LW  = 3'd0;
  localparam logic [2:0] F_LH  = 3'd1;
  localparam logic [2:0] F_LB  = 3'd2;
  localparam logic [2:0] F_LHU = 3'd3;
  localparam logic [2:0] F_LBU = 3'd4;
  localparam logic [2:0] F_SW  = 3'd5;
  localparam logic [2:0] F_SH  = 3'd6;
  localparam logic [2:0] F_SB  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       func_q;
  logic [1:0]       addr_lo;
  logic             addr_bad;
  logic             expire;

  function automatic logic is_store(input logic [2:0] f);
    return (f == F_SW) || (f == F_SH) || (f == F_SB);
  endfunction

  function automatic logic misaligned_f(input logic [2:0] f, input logic [1:0] a);
    case (f)
      F_LW, F_SW:        return a != 2'b00;
      F_LH, F_LHU, F_SH: return a[0];
      default:           return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_f(input logic [2:0] f, input logic [1:0] a);
    case (f)
      F_LW, F_SW:        return 4'b1111;
      F_LH, F_LHU, F_SH: return a[1] ? 4'b1100 : 4'b0011;
      default:           return 4'b0001 << a;
    endcase
  endfunction

  function automatic logic [31:0] lanes_f(input logic [2:0] f, input logic [31:0] d);
    case (f)
      F_SW:    return d;
      F_SH:    return {2{d[15:0]}};
      F_SB:    return {4{d[7:0]}};
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f)
      F_LB:    return {{24{b[7]}}, b};
      F_LBU:   return {24'b0, b};
      F_LH:    return {{16{h[15]}}, h};
      F_LHU:   return {16'b0, h};
      default: return d;
    endcase
  endfunction

  assign addr_bad       = misaligned_f(lsu_func, lsu_addr[1:0]);
  assign expire         = cnt >= CNT_W'(TIMEOUT_CYCLES - 2);
  assign lsu_misaligned = !rst && (state == S_IDLE) && lsu_req_valid && addr_bad;
  assign lsu_stall      = !rst && ((state == S_REQ) || (state == S_WAIT) ||
                                   ((state == S_IDLE) && lsu_req_valid && !addr_bad));

  // Bus outputs are loaded on entry to REQ and cleared when REQ is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      func_q        <= '0;
      addr_lo       <= '0;
      lsu_done      <= 1'b0;
      lsu_bus_err   <= 1'b0;
      lsu_rdata     <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_be    <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      lsu_done    <= 1'b0;
      lsu_bus_err <= 1'b0;
      case (state)
        S_IDLE: begin
          lsu_rdata <= '0;
          if (lsu_req_valid && !addr_bad) begin
            state         <= S_REQ;
            cnt           <= '0;
            func_q        <= lsu_func;
            addr_lo       <= lsu_addr[1:0];
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_store(lsu_func);
            mem.mem_be    <= be_f(lsu_func, lsu_addr[1:0]);
            mem.mem_addr  <= {lsu_addr[31:2], 2'b00};
            mem.mem_wdata <= lanes_f(lsu_func, lsu_wdata);
          end
        end
        S_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (mem.mem_gnt || expire) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
          end
          if (mem.mem_gnt) begin
            state    <= is_store(func_q) ? S_DONE : S_WAIT;
            lsu_done <= is_store(func_q);
          end else if (expire) begin
            state       <= S_DONE;
            lsu_done    <= 1'b1;
            lsu_bus_err <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (mem.mem_rvalid) begin
            state     <= S_DONE;
            lsu_done  <= 1'b1;
            lsu_rdata <= load_fmt(func_q, addr_lo, mem.mem_rdata);
          end else if (expire) begin
            state       <= S_DONE;
            lsu_done    <= 1'b1;
            lsu_bus_err <= 1'b1;
            lsu_rdata   <= '0;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          lsu_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_controller.sv
// Scoreboard bench for lsu_mem_controller: expected bus/result records are queued
// per access and compared against what the controller does on the bus and core side.
module tb_lsu_mem_controller;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LB = 3'd2, LHU = 3'd3, LBU = 3'd4;
  localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk;
  logic        rst;
  logic        lsu_req_valid;
  logic [2:0]  lsu_func;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_stall;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misaligned;
  logic        lsu_bus_err;

  lsu_mem_controller_if mem_bus ();

  lsu_mem_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_func       (lsu_func),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_stall      (lsu_stall),
    .lsu_done       (lsu_done),
    .lsu_rdata      (lsu_rdata),
    .lsu_misaligned (lsu_misaligned),
    .lsu_bus_err    (lsu_bus_err),
    .mem            (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gd: REQ cycles before gnt (0 = first REQ cycle, -1 = never)
  typedef struct {
    string       nm;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] md;
    int          gd;
  } stim_t;

  // bus = {we, be, addr, wdata} on the first request cycle; res = {bus_err, rdata}
  typedef struct {
    logic [68:0] bus;
    logic [32:0] res;
    int          done_cyc;
  } exp_t;

  typedef struct {
    logic [68:0] bus;
    logic [32:0] res;
    int          done_cyc;
    int          req_cyc;
    logic        stall0;
    logic        misal;
    bit          stall_bad;
    logic        reissue;
  } obs_t;

  exp_t  sb[$];
  stim_t sq[$];
  int    checks;
  int    errors;

  // Drives one access, plays the memory, records what the controller did (cycle 0 = request cycle).
  task automatic run_txn(input stim_t s, input int max_cyc, output obs_t o);
    int reqc;
    bit gnt_prev;
    bit done;
    bit is_load;
    reqc       = 0;
    gnt_prev   = 0;
    done       = 0;
    is_load    = (s.f < SW);
    o.bus      = '0;
    o.res      = '0;
    o.done_cyc = -1;
    o.stall_bad = 0;
    @(negedge clk);
    lsu_req_valid = 1'b1;
    lsu_func      = s.f;
    lsu_addr      = s.a;
    lsu_wdata     = s.wd;
    #1;
    o.stall0 = lsu_stall;
    o.misal  = lsu_misaligned;
    for (int c = 1; c <= max_cyc && !done; c++) begin
      @(negedge clk);
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      if (mem_bus.mem_req === 1'b1) begin
        reqc++;
        if (reqc == 1)
          o.bus = {mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_addr, mem_bus.mem_wdata};
      end
      if (lsu_done === 1'b1) begin
        done       = 1;
        o.done_cyc = c;
        o.res      = {lsu_bus_err, lsu_rdata};
        if (lsu_stall !== 1'b0) o.stall_bad = 1;
      end else if (lsu_stall !== 1'b1) begin
        o.stall_bad = 1;
      end
      if (gnt_prev && is_load) begin
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = s.md;
      end
      gnt_prev = 0;
      if (mem_bus.mem_req === 1'b1 && s.gd >= 0 && reqc > s.gd) begin
        mem_bus.mem_gnt = 1'b1;
        gnt_prev        = 1;
      end
    end
    o.req_cyc = reqc;
    // lsu_req_valid stays high through DONE; the controller must not reissue it
    @(posedge clk);
    #1;
    o.reissue          = mem_bus.mem_req;
    lsu_req_valid      = 1'b0;
    mem_bus.mem_gnt    = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    lsu_req_valid = 1'b1;
    lsu_func      = LW;
    lsu_addr      = 32'h100;
    repeat (3) @(negedge clk);
    checks++;
    if ({lsu_stall, lsu_misaligned} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_stall got %b want 00", {lsu_stall, lsu_misaligned});
    end
    checks++;
    if ({lsu_done, lsu_bus_err, lsu_rdata} !== 34'h0) begin
      errors++;
      $display("[TB] FAIL reset_core got %h want 0", {lsu_done, lsu_bus_err, lsu_rdata});
    end
    checks++;
    if ({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_addr, mem_bus.mem_wdata} !== 70'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus got %h want 0",
               {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_addr, mem_bus.mem_wdata});
    end
    lsu_req_valid = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    checks++;
    if ({lsu_stall, mem_bus.mem_req, lsu_done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_release got %b want 000", {lsu_stall, mem_bus.mem_req, lsu_done});
    end
  endtask

  task automatic test_loads();
    obs_t o;
    exp_t e;
    sq.push_back('{nm:"lw_100",  f:LW,  a:32'h100, wd:32'h0, md:32'hDEADBEEF, gd:0});
    sb.push_back('{bus:{1'b0, 4'b1111, 32'h100, 32'h0}, res:{1'b0, 32'hDEADBEEF}, done_cyc:3});
    sq.push_back('{nm:"lb_203",  f:LB,  a:32'h203, wd:32'h0, md:32'h80112233, gd:0});
    sb.push_back('{bus:{1'b0, 4'b1000, 32'h200, 32'h0}, res:{1'b0, 32'hFFFFFF80}, done_cyc:3});
    sq.push_back('{nm:"lbu_203", f:LBU, a:32'h203, wd:32'h0, md:32'h80112233, gd:0});
    sb.push_back('{bus:{1'b0, 4'b1000, 32'h200, 32'h0}, res:{1'b0, 32'h00000080}, done_cyc:3});
    sq.push_back('{nm:"lhu_302", f:LHU, a:32'h302, wd:32'h0, md:32'hBEEF1234, gd:0});
    sb.push_back('{bus:{1'b0, 4'b1100, 32'h300, 32'h0}, res:{1'b0, 32'h0000BEEF}, done_cyc:3});
    sq.push_back('{nm:"lh_302",  f:LH,  a:32'h302, wd:32'h0, md:32'hBEEF1234, gd:0});
    sb.push_back('{bus:{1'b0, 4'b1100, 32'h300, 32'h0}, res:{1'b0, 32'hFFFFBEEF}, done_cyc:3});
    sq.push_back('{nm:"lh_300",  f:LH,  a:32'h300, wd:32'h0, md:32'h12347FFF, gd:0});
    sb.push_back('{bus:{1'b0, 4'b0011, 32'h300, 32'h0}, res:{1'b0, 32'h00007FFF}, done_cyc:3});
    sq.push_back('{nm:"lbu_201", f:LBU, a:32'h201, wd:32'h0, md:32'h0000A500, gd:0});
    sb.push_back('{bus:{1'b0, 4'b0010, 32'h200, 32'h0}, res:{1'b0, 32'h000000A5}, done_cyc:3});
    sq.push_back('{nm:"lb_200",  f:LB,  a:32'h200, wd:32'h0, md:32'hFFFFFF7F, gd:0});
    sb.push_back('{bus:{1'b0, 4'b0001, 32'h200, 32'h0}, res:{1'b0, 32'h0000007F}, done_cyc:3});
    sq.push_back('{nm:"lw_slow", f:LW,  a:32'h40C, wd:32'hFFFF, md:32'h01234567, gd:2});
    sb.push_back('{bus:{1'b0, 4'b1111, 32'h40C, 32'h0}, res:{1'b0, 32'h01234567}, done_cyc:5});
    while (sq.size() > 0) begin
      stim_t s;
      s = sq.pop_front();
      run_txn(s, 12, o);
      e = sb.pop_front();
      checks++;
      if (o.bus !== e.bus) begin
        errors++;
        $display("[TB] FAIL %s bus got %h want %h", s.nm, o.bus, e.bus);
      end
      checks++;
      if (o.res !== e.res) begin
        errors++;
        $display("[TB] FAIL %s result got %h want %h", s.nm, o.res, e.res);
      end
      checks++;
      if (o.done_cyc != e.done_cyc) begin
        errors++;
        $display("[TB] FAIL %s done_cycle got %0d want %0d", s.nm, o.done_cyc, e.done_cyc);
      end
      checks++;
      if ({o.stall0, o.stall_bad, o.reissue} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL %s stall got %b want 100", s.nm, {o.stall0, o.stall_bad, o.reissue});
      end
    end
  endtask

  task automatic test_stores();
    obs_t o;
    exp_t e;
    sq.push_back('{nm:"sb_101", f:SB, a:32'h101, wd:32'h000000AB, md:32'h0, gd:0});
    sb.push_back('{bus:{1'b1, 4'b0010, 32'h100, 32'hABABABAB}, res:33'h0, done_cyc:2});
    sq.push_back('{nm:"sh_102", f:SH, a:32'h102, wd:32'h00001234, md:32'h0, gd:0});
    sb.push_back('{bus:{1'b1, 4'b1100, 32'h100, 32'h12341234}, res:33'h0, done_cyc:2});
    sq.push_back('{nm:"sw_204", f:SW, a:32'h204, wd:32'hCAFEF00D, md:32'h0, gd:0});
    sb.push_back('{bus:{1'b1, 4'b1111, 32'h204, 32'hCAFEF00D}, res:33'h0, done_cyc:2});
    sq.push_back('{nm:"sb_103", f:SB, a:32'h103, wd:32'h12345678, md:32'h0, gd:0});
    sb.push_back('{bus:{1'b1, 4'b1000, 32'h100, 32'h78787878}, res:33'h0, done_cyc:2});
    sq.push_back('{nm:"sb_002", f:SB, a:32'h002, wd:32'hFFFFFF5A, md:32'h0, gd:0});
    sb.push_back('{bus:{1'b1, 4'b0100, 32'h000, 32'h5A5A5A5A}, res:33'h0, done_cyc:2});
    sq.push_back('{nm:"sh_slow", f:SH, a:32'h300, wd:32'hABCD5678, md:32'h0, gd:3});
    sb.push_back('{bus:{1'b1, 4'b0011, 32'h300, 32'h56785678}, res:33'h0, done_cyc:5});
    while (sq.size() > 0) begin
      stim_t s;
      s = sq.pop_front();
      run_txn(s, 12, o);
      e = sb.pop_front();
      checks++;
      if (o.bus !== e.bus) begin
        errors++;
        $display("[TB] FAIL %s bus got %h want %h", s.nm, o.bus, e.bus);
      end
      checks++;
      if (o.res !== e.res || o.done_cyc != e.done_cyc) begin
        errors++;
        $display("[TB] FAIL %s result/cycle got %h/%0d want %h/%0d",
                 s.nm, o.res, o.done_cyc, e.res, e.done_cyc);
      end
      checks++;
      if ({o.stall0, o.stall_bad, o.reissue} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL %s stall got %b want 100", s.nm, {o.stall0, o.stall_bad, o.reissue});
      end
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    exp_t e;
    sq.push_back('{nm:"mis_lw_102",  f:LW,  a:32'h102, wd:32'h0, md:32'h0, gd:0});
    sq.push_back('{nm:"mis_sh_105",  f:SH,  a:32'h105, wd:32'h0, md:32'h0, gd:0});
    sq.push_back('{nm:"mis_lhu_301", f:LHU, a:32'h301, wd:32'h0, md:32'h0, gd:0});
    sq.push_back('{nm:"mis_sw_003",  f:SW,  a:32'h003, wd:32'h0, md:32'h0, gd:0});
    sq.push_back('{nm:"mis_lh_0ff",  f:LH,  a:32'h0FF, wd:32'h0, md:32'h0, gd:0});
    for (int i = 0; i < 5; i++)
      sb.push_back('{bus:69'h0, res:33'h0, done_cyc:-1});
    while (sq.size() > 0) begin
      stim_t s;
      s = sq.pop_front();
      run_txn(s, 3, o);
      e = sb.pop_front();
      checks++;
      if ({o.misal, o.stall0} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL %s misaligned/stall got %b want 10", s.nm, {o.misal, o.stall0});
      end
      checks++;
      if (o.req_cyc != 0 || o.bus !== e.bus || o.done_cyc != e.done_cyc) begin
        errors++;
        $display("[TB] FAIL %s bus_activity got req=%0d done=%0d want req=0 done=%0d",
                 s.nm, o.req_cyc, o.done_cyc, e.done_cyc);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    exp_t e;
    sq.push_back('{nm:"to_lw_nognt",  f:LW,  a:32'h500, wd:32'h0,      md:32'h0,      gd:-1});
    sb.push_back('{bus:{1'b0, 4'b1111, 32'h500, 32'h0}, res:{1'b1, 32'h0}, done_cyc:16});
    sq.push_back('{nm:"to_sw_gnt_edge", f:SW, a:32'h504, wd:32'h11223344, md:32'h0, gd:14});
    sb.push_back('{bus:{1'b1, 4'b1111, 32'h504, 32'h11223344}, res:{1'b0, 32'h0}, done_cyc:16});
    sq.push_back('{nm:"to_lbu_rvalid_edge", f:LBU, a:32'h507, wd:32'h0, md:32'hAA000000, gd:13});
    sb.push_back('{bus:{1'b0, 4'b1000, 32'h504, 32'h0}, res:{1'b0, 32'h000000AA}, done_cyc:16});
    sq.push_back('{nm:"to_sb_nognt",  f:SB,  a:32'h508, wd:32'h00000033, md:32'h0, gd:-1});
    sb.push_back('{bus:{1'b1, 4'b0001, 32'h508, 32'h33333333}, res:{1'b1, 32'h0}, done_cyc:16});
    while (sq.size() > 0) begin
      stim_t s;
      s = sq.pop_front();
      run_txn(s, 24, o);
      e = sb.pop_front();
      checks++;
      if (o.bus !== e.bus) begin
        errors++;
        $display("[TB] FAIL %s bus got %h want %h", s.nm, o.bus, e.bus);
      end
      checks++;
      if (o.res !== e.res) begin
        errors++;
        $display("[TB] FAIL %s err_result got %h want %h", s.nm, o.res, e.res);
      end
      checks++;
      if (o.done_cyc != e.done_cyc || o.stall_bad) begin
        errors++;
        $display("[TB] FAIL %s done_cycle got %0d stall_bad=%0d want %0d stall_bad=0",
                 s.nm, o.done_cyc, o.stall_bad, e.done_cyc);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit saw_done;
    saw_done = 0;
    @(negedge clk);
    lsu_req_valid = 1'b1;
    lsu_func      = LW;
    lsu_addr      = 32'h100;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b1;
    @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    checks++;
    if ({mem_bus.mem_req, lsu_stall} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL midreset_wait got %b want 01", {mem_bus.mem_req, lsu_stall});
    end
    rst           = 1'b1;
    lsu_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({mem_bus.mem_req, lsu_stall, lsu_done, lsu_bus_err, lsu_rdata} !== 36'h0) begin
      errors++;
      $display("[TB] FAIL midreset_idle got %h want 0",
               {mem_bus.mem_req, lsu_stall, lsu_done, lsu_bus_err, lsu_rdata});
    end
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata  = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_bus.mem_rvalid = 1'b0;
      if (lsu_done !== 1'b0 || lsu_stall !== 1'b0 || mem_bus.mem_req !== 1'b0) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("[TB] FAIL midreset_late_rvalid got activity=1 want activity=0");
    end
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    rst                = 1'b1;
    lsu_req_valid      = 1'b0;
    lsu_func           = 3'd0;
    lsu_addr           = 32'h0;
    lsu_wdata          = 32'h0;
    mem_bus.mem_gnt    = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_controller.md
Name: lsu_mem_controller

Overview:
- Multi-cycle load/store sequencer between the single-cycle core's decode/execute stage and a req/gnt/rvalid data-memory port.
- Takes the decoded load/store function code plus the ALU-computed effective address and store data.
- Issues word-aligned memory transactions with byte enables, formats load data with sign or zero extension, and stalls the core until the access retires.
- Detects misaligned addresses and memory timeouts, and reports both as single-cycle error pulses.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in REQ+WAIT before a bus error; must be ≥2.
- CNT_W, $clog2(TIMEOUT_CYCLES)+1: width of the timeout counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- lsu_req_valid  in  1  current instruction is a load/store.
- lsu_func  in  3  load_store_func_code: LW=0, LH=1, LB=2, LHU=3, LBU=4, SW=5, SH=6, SB=7.
- lsu_addr  in  32  effective address (rs1 + immediate).
- lsu_wdata  in  32  rs2 store data.
- lsu_stall  out  1  hold PC and regfile write.
- lsu_done  out  1  one-cycle retire pulse.
- lsu_rdata  out  32  formatted load result; valid when lsu_done is high and the access is a load.
- lsu_misaligned  out  1  misaligned-address exception pulse.
- lsu_bus_err  out  1  timeout exception pulse.
- mem_req  out  1  request.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word address; bits [1:0] are always 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; latched address, function, data and the timeout counter cleared. Reset mid-transaction abandons the access: mem_req is low in the cycle after the reset edge, and a late mem_rvalid in IDLE is ignored.
- Alignment: misaligned if (LW/SW and addr[1:0]≠0) or (LH/LHU/SH and addr[0]≠0); byte accesses are never misaligned.
- IDLE:
  - lsu_req_valid and misaligned: lsu_misaligned=1 for this cycle; no memory request; lsu_stall=0; stay in IDLE.
  - lsu_req_valid and aligned: latch addr, func and wdata; lsu_stall=1 (combinational, same cycle); go to REQ.
- REQ:
  - mem_req=1; mem_addr={addr[31:2],2'b00}; mem_we=1 for SW/SH/SB.
  - On mem_gnt: stores go to DONE; loads go to WAIT.
  - mem_rvalid while in REQ is ignored; memory never returns rvalid before the cycle after gnt.
- WAIT: mem_req=0. On mem_rvalid, register the formatted result and go to DONE.
- DONE:
  - lsu_done=1, lsu_stall=0; the core retires the instruction. Next state is IDLE.
  - lsu_req_valid in DONE belongs to the retiring instruction and is ignored.
- lsu_stall is 1 in REQ and WAIT, and in IDLE when an aligned request is present. It is 0 otherwise.
- Timeout:
  - Counter is cleared on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without the awaited gnt/rvalid, go to DONE with lsu_bus_err=1 alongside lsu_done and lsu_rdata=0; no regfile write.
  - A gnt/rvalid arriving in the same cycle as the expiry wins: normal completion, no error.
- Byte enables and store data:
  - SW: be=4'b1111, wdata unchanged.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata={2{wdata[15:0]}}.
  - SB: be = 4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - Loads drive be of the same shape; mem_wdata=0.
- Load formatting:
  - Select the lane by latched addr[1:0] (half: addr[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Minimum latency (gnt in the first REQ cycle): store = 3 cycles (IDLE, REQ, DONE); load = 4 cycles when rvalid arrives one cycle after gnt.

Test Plan:
- LW addr=0x100: gnt in the first REQ cycle, rvalid one cycle later with 0xDEADBEEF -> mem_addr=0x100, be=1111, lsu_rdata=0xDEADBEEF with lsu_done at cycle 3; stall high cycles 0–2.
- LB addr=0x203, rdata=0x80112233 -> be=1000, lsu_rdata=0xFFFFFF80. LBU on the same data -> 0x00000080.
- LHU addr=0x302, rdata=0xBEEF1234 -> be=1100, lsu_rdata=0x0000BEEF. LH -> 0xFFFFBEEF.
- SB addr=0x101, wdata=0x000000AB -> mem_we=1, mem_addr=0x100, be=0010, mem_wdata=0xABABABAB, done at cycle 2. SH addr=0x102, wdata=0x1234 -> be=1100, mem_wdata=0x12341234.
- LW addr=0x102 and SH addr=0x105 -> lsu_misaligned pulse, mem_req never asserted, stall 0.
- Timeout and reset:
  - Load with gnt never asserted -> lsu_bus_err and lsu_done at cycle TIMEOUT_CYCLES (16).
  - rst asserted in WAIT -> IDLE next cycle, all outputs 0; a later rvalid produces no lsu_done.
